// File: rtl/alu_pkg.sv
// Shared types and constants for the shared-ALU arbiter.
// Op codes are listed in ALU result-mux input order.
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int ALU_OPW   = 3;

  localparam logic [ALU_OPW-1:0] OP_AND  = 3'd0;
  localparam logic [ALU_OPW-1:0] OP_OR   = 3'd1;
  localparam logic [ALU_OPW-1:0] OP_XOR  = 3'd2;
  localparam logic [ALU_OPW-1:0] OP_ADD  = 3'd3;
  localparam logic [ALU_OPW-1:0] OP_SUB  = 3'd4;
  localparam logic [ALU_OPW-1:0] OP_PASA = 3'd5;
  localparam logic [ALU_OPW-1:0] OP_PASB = 3'd6;
  localparam logic [ALU_OPW-1:0] OP_NOTA = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the pointer moves past the winner
// only when a grant is actually issued.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic ptr;

  always_comb begin
    gnt_id = 1'b0;
    if (req[0] & req[1]) gnt_id = ptr;
    else if (req[1])     gnt_id = 1'b1;
    gnt = 2'b00;
    if (en & |req) gnt[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)       ptr <= 1'b0;
    else if (|gnt) ptr <= ~gnt_id;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters: arbitrate, drive the
// operands and mux select, wait for settle, return the result.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int OPW     = ALU_OPW,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             busy
);

  localparam int CW = 4;

  state_t          state;
  logic            owner;
  logic [CW-1:0]   cnt;
  logic [1:0]      gnt;
  logic            gnt_id;
  logic            rsp_hs;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({req1_valid, req0_valid}),
    .en     (state == IDLE),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign busy       = (state != IDLE);
  assign rsp_hs     = owner ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rsp0_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_valid <= 1'b0;
      rsp1_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|gnt) begin
            owner   <= gnt_id;
            alu_sel <= gnt_id ? req1_op : req0_op;
            alu_a   <= gnt_id ? req1_a : req0_a;
            alu_b   <= gnt_id ? req1_b : req0_b;
            cnt     <= CW'(ALU_LAT - 1);
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            if (owner) begin
              rsp1_data  <= alu_result;
              rsp1_valid <= 1'b1;
            end else begin
              rsp0_data  <= alu_result;
              rsp0_valid <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_hs) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Two instances (settle latency 1 and 3) driven by the same
// stimulus, each checked against a transaction-level model.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [2:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp0_ready, rsp1_ready;
  logic [7:0] salt;

  logic [1:0] req0_ready, req1_ready;
  logic [1:0] rsp0_valid, rsp1_valid, busy;
  logic [7:0] alu_a [2];
  logic [7:0] alu_b [2];
  logic [2:0] alu_sel [2];
  logic [7:0] alu_result [2];
  logic [7:0] rsp0_data [2];
  logic [7:0] rsp1_data [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat [2] = '{1, 3};

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(
    input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_PASA: return a;
      OP_PASB: return b;
      default: return ~a;
    endcase
  endfunction

  // salt perturbs the result every cycle so the capture cycle matters
  always_comb begin
    for (int k = 0; k < 2; k++)
      alu_result[k] = alu_f(alu_sel[k], alu_a[k], alu_b[k]) ^ salt;
  end

  alu_share_arbiter #(.ALU_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready[0]),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready[0]),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_sel(alu_sel[0]),
    .alu_result(alu_result[0]),
    .rsp0_valid(rsp0_valid[0]), .rsp0_ready(rsp0_ready),
    .rsp0_data(rsp0_data[0]),
    .rsp1_valid(rsp1_valid[0]), .rsp1_ready(rsp1_ready),
    .rsp1_data(rsp1_data[0]),
    .busy(busy[0])
  );

  alu_share_arbiter #(.ALU_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready[1]),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready[1]),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_sel(alu_sel[1]),
    .alu_result(alu_result[1]),
    .rsp0_valid(rsp0_valid[1]), .rsp0_ready(rsp0_ready),
    .rsp0_data(rsp0_data[1]),
    .rsp1_valid(rsp1_valid[1]), .rsp1_ready(rsp1_ready),
    .rsp1_data(rsp1_data[1]),
    .busy(busy[1])
  );

  // model: accept cycle, owner, preferred requester, latched op
  int         m_acc [2];
  int         m_own [2];
  bit         m_pref [2];
  bit         m_rchk [2];
  logic [2:0] m_op [2];
  logic [7:0] m_a [2];
  logic [7:0] m_b [2];
  logic [7:0] m_d [2];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(
    input bit v0, input logic [2:0] o0,
    input logic [7:0] a0, input logic [7:0] b0,
    input bit v1, input logic [2:0] o1,
    input logic [7:0] a1, input logic [7:0] b1,
    input bit r0, input bit r1, input bit rs,
    input logic [7:0] sl);
    bit idle, has_g, g, rv, hs;
    string p;
    @(negedge clk);
    rst = rs;
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    rsp0_ready = r0; rsp1_ready = r1; salt = sl;
    #1;
    for (int k = 0; k < 2; k++) begin
      p = $sformatf("L%0d_", lat[k]);
      if (rs) begin
        m_acc[k] = -1; m_own[k] = 0; m_pref[k] = 1'b0;
        m_op[k] = '0; m_a[k] = '0; m_b[k] = '0; m_d[k] = '0;
        m_rchk[k] = 1'b1;
        continue;
      end
      idle  = (m_acc[k] < 0);
      has_g = idle && (v0 || v1);
      g     = (v0 && v1) ? m_pref[k] : v1;
      rv    = !idle && (cyc >= m_acc[k] + lat[k] + 1);
      chk({p, "rdy0"}, 32'(req0_ready[k]), 32'(has_g && !g));
      chk({p, "rdy1"}, 32'(req1_ready[k]), 32'(has_g && g));
      chk({p, "busy"}, 32'(busy[k]), 32'(!idle));
      chk({p, "rspv0"}, 32'(rsp0_valid[k]), 32'(rv && m_own[k] == 0));
      chk({p, "rspv1"}, 32'(rsp1_valid[k]), 32'(rv && m_own[k] == 1));
      chk({p, "sel"}, 32'(alu_sel[k]), 32'(m_op[k]));
      chk({p, "opa"}, 32'(alu_a[k]), 32'(m_a[k]));
      chk({p, "opb"}, 32'(alu_b[k]), 32'(m_b[k]));
      if (rv && m_own[k] == 0) chk({p, "rsp0d"}, 32'(rsp0_data[k]), 32'(m_d[k]));
      if (rv && m_own[k] == 1) chk({p, "rsp1d"}, 32'(rsp1_data[k]), 32'(m_d[k]));
      if (m_rchk[k]) begin
        chk({p, "rst_d0"}, 32'(rsp0_data[k]), 32'd0);
        chk({p, "rst_d1"}, 32'(rsp1_data[k]), 32'd0);
        m_rchk[k] = 1'b0;
      end
      if (has_g) begin
        m_acc[k] = cyc; m_own[k] = int'(g); m_pref[k] = !g;
        m_op[k] = g ? o1 : o0;
        m_a[k]  = g ? a1 : a0;
        m_b[k]  = g ? b1 : b0;
      end else if (!idle) begin
        if (cyc == m_acc[k] + lat[k])
          m_d[k] = alu_f(m_op[k], m_a[k], m_b[k]) ^ sl;
        hs = (m_own[k] == 1) ? r1 : r0;
        if (rv && hs) m_acc[k] = -1;
      end
    end
    cyc++;
  endtask

  task automatic idle_cycles(input int n, input bit r0, input bit r1);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0, r0, r1, 0, 8'h00);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0;
    req0_op = 0; req1_op = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    rsp0_ready = 0; rsp1_ready = 0; salt = 0;

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00);
    idle_cycles(1, 0, 0);

    // single requester, op 3 on 12/34
    step(1, 3'd3, 8'h12, 8'h34, 0, 0, 0, 0, 1, 1, 0, 8'h00);
    idle_cycles(7, 1, 1);

    // both requesting continuously: strict alternation
    for (int i = 0; i < 20; i++)
      step(1, 3'd3, 8'(i), 8'h05, 1, 3'd4, 8'h80, 8'(i),
           1, 1, 0, 8'h00);
    idle_cycles(6, 1, 1);

    // response back-pressure while requester 1 waits
    step(1, 3'd2, 8'hf0, 8'h3c, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++)
      step(0, 0, 0, 0, 1, 3'd1, 8'h0f, 8'h50, 0, 1, 0, 8'h00);
    for (int i = 0; i < 10; i++)
      step(0, 0, 0, 0, 1, 3'd1, 8'h0f, 8'h50, 1, 1, 0, 8'h00);
    idle_cycles(6, 1, 1);

    // reset while in flight, then a normal req1
    step(0, 0, 0, 0, 1, 3'd5, 8'haa, 8'h55, 1, 1, 0, 8'h00);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 8'h00);
    step(0, 0, 0, 0, 1, 3'd6, 8'h11, 8'h22, 1, 1, 0, 8'h00);
    idle_cycles(7, 1, 1);

    // every op code in turn
    for (int op = 0; op < 8; op++) begin
      step(1, 3'(op), 8'h9c, 8'h27, 0, 0, 0, 0, 1, 1, 0, 8'h00);
      idle_cycles(6, 1, 1);
    end

    // random traffic, back-pressure, salted results, rare resets
    for (int i = 0; i < 400; i++)
      step(($urandom % 3) != 0, 3'($urandom), 8'($urandom),
           8'($urandom),
           ($urandom % 3) != 0, 3'($urandom), 8'($urandom),
           8'($urandom),
           ($urandom % 4) != 0, ($urandom % 4) != 0,
           ($urandom % 80) == 0, 8'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
